// File: rtl/wifi_txbuf_pkg.sv
// Shared types, sizes and CRC-32 helper for the WiFi TX stream buffer.
// The CRC helper is only referenced when WIFI_TX_FCS_EN is defined.
package wifi_txbuf_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_FIFO  = 8;
    localparam int unsigned LEN_W      = ADDR_FIFO + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM,
        ST_FCS,
        ST_DONE
    } state_t;

    localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    // Reflected CRC-32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data_byte);
        logic [31:0] c;
        c = crc ^ {24'd0, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/wifi_tx_stream_buffer_if.sv
// Byte stream valid/ready bus from the TX buffer to the scrambler/encoder.
interface wifi_tx_stream_buffer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/wifi_tx_word_ram.sv
// Simple dual-port word RAM: synchronous write, registered read, read-first on collision.
module wifi_tx_word_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Both ports use non-blocking updates, so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/wifi_tx_stream_buffer.sv
// Captures slicer word writes into a local RAM and replays them as a byte stream.
// Optional CRC-32 FCS trailer enabled with `define WIFI_TX_FCS_EN.
module wifi_tx_stream_buffer
    import wifi_txbuf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = wifi_txbuf_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_FIFO  = wifi_txbuf_pkg::ADDR_FIFO,
    parameter int unsigned LEN_W      = ADDR_FIFO + 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_FIFO-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   tx_start,
    input  logic [LEN_W-1:0]       tx_len,
    input  logic                   tx_abort,
    output logic                   busy,
    output logic                   done,
    wifi_tx_stream_buffer_if.master tx_if
);

`ifdef WIFI_TX_FCS_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    state_t                  r_state,    w_state_nxt;
    logic [LEN_W-1:0]        r_len,      w_len_nxt;
    logic [LEN_W-1:0]        r_byte_cnt, w_cnt_nxt;
    logic [ADDR_FIFO-1:0]    r_word_ptr, w_ptr_nxt;
    logic [DATA_WIDTH-1:0]   r_word,     w_word_nxt;
    logic                    r_busy,     w_busy_nxt;
    logic                    r_done,     w_done_nxt;
    logic [7:0]              r_out_data, w_data_nxt;
    logic                    r_out_valid, w_valid_nxt;
    logic                    r_out_last, w_last_nxt;

    logic                    w_rd_en;
    logic [ADDR_FIFO-1:0]    w_rd_addr;
    logic [DATA_WIDTH-1:0]   w_ram_rd;
    logic [LEN_W-1:0]        w_cnt_inc;
    logic [LEN_W-1:0]        w_len_m1;
    logic [ADDR_FIFO-1:0]    w_ptr_inc;
    logic                    w_accept;

`ifdef WIFI_TX_FCS_EN
    logic [31:0]             r_crc,     w_crc_nxt;
    logic [1:0]              r_fcs_idx, w_fcs_idx_nxt;
    logic [31:0]             w_crc_upd;
    logic [31:0]             w_fcs_word;
    logic [1:0]              w_fcs_idx_inc;

    assign w_crc_upd     = crc32_byte(r_crc, r_out_data);
    assign w_fcs_word    = r_crc ^ CRC_XOROUT;
    assign w_fcs_idx_inc = 2'(r_fcs_idx + 2'd1);
`endif

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] s);
        return w[{s, 3'b000} +: 8];
    endfunction

    wifi_tx_word_ram #(
        .DW (DATA_WIDTH),
        .AW (ADDR_FIFO)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_rd)
    );

    assign w_cnt_inc = LEN_W'(r_byte_cnt + LEN_W'(1));
    assign w_len_m1  = LEN_W'(r_len - LEN_W'(1));
    assign w_ptr_inc = ADDR_FIFO'(r_word_ptr + ADDR_FIFO'(1));
    assign w_accept  = r_out_valid && tx_if.out_ready;

    // The RAM read is issued on entry to FETCH so the word is ready at FETCH's closing edge.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_byte_cnt;
        w_ptr_nxt   = r_word_ptr;
        w_word_nxt  = r_word;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_data_nxt  = r_out_data;
        w_valid_nxt = r_out_valid;
        w_last_nxt  = r_out_last;
        w_rd_en     = 1'b0;
        w_rd_addr   = r_word_ptr;
`ifdef WIFI_TX_FCS_EN
        w_crc_nxt     = r_crc;
        w_fcs_idx_nxt = r_fcs_idx;
`endif

        case (r_state)
            ST_IDLE: begin
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                if (tx_start && (tx_len != '0)) begin
                    w_len_nxt   = tx_len;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = '0;
                    w_rd_en     = 1'b1;
                    w_rd_addr   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_FETCH;
`ifdef WIFI_TX_FCS_EN
                    w_crc_nxt   = CRC_INIT;
`endif
                end
            end

            ST_FETCH: begin
                w_word_nxt  = w_ram_rd;
                w_data_nxt  = byte_sel(w_ram_rd, r_byte_cnt[1:0]);
                w_valid_nxt = 1'b1;
                w_last_nxt  = !FCS_ON && (r_byte_cnt == w_len_m1);
                w_state_nxt = ST_STREAM;
            end

            ST_STREAM: begin
                if (w_accept) begin
                    w_cnt_nxt = w_cnt_inc;
`ifdef WIFI_TX_FCS_EN
                    w_crc_nxt = w_crc_upd;
`endif
                    if (r_byte_cnt == w_len_m1) begin
`ifdef WIFI_TX_FCS_EN
                        w_fcs_idx_nxt = 2'd0;
                        w_data_nxt    = byte_sel(w_crc_upd ^ CRC_XOROUT, 2'd0);
                        w_last_nxt    = 1'b0;
                        w_state_nxt   = ST_FCS;
`else
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
`endif
                    end else if (r_byte_cnt[1:0] == 2'd3) begin
                        w_ptr_nxt   = w_ptr_inc;
                        w_rd_en     = 1'b1;
                        w_rd_addr   = w_ptr_inc;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_data_nxt = byte_sel(r_word, w_cnt_inc[1:0]);
                        w_last_nxt = !FCS_ON && (w_cnt_inc == w_len_m1);
                    end
                end
            end

`ifdef WIFI_TX_FCS_EN
            ST_FCS: begin
                if (w_accept) begin
                    if (r_fcs_idx == 2'd3) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_fcs_idx_nxt = w_fcs_idx_inc;
                        w_data_nxt    = byte_sel(w_fcs_word, w_fcs_idx_inc);
                        w_last_nxt    = (w_fcs_idx_inc == 2'd3);
                    end
                end
            end
`endif

            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides every transition, including the final handshake.
        if (tx_abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_rd_en     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_word_ptr  <= '0;
            r_word      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
`ifdef WIFI_TX_FCS_EN
            r_crc       <= '0;
            r_fcs_idx   <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_byte_cnt  <= w_cnt_nxt;
            r_word_ptr  <= w_ptr_nxt;
            r_word      <= w_word_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
`ifdef WIFI_TX_FCS_EN
            r_crc       <= w_crc_nxt;
            r_fcs_idx   <= w_fcs_idx_nxt;
`endif
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign tx_if.out_data  = r_out_data;
    assign tx_if.out_valid = r_out_valid;
    assign tx_if.out_last  = r_out_last;

endmodule

// File: tb/tb_wifi_tx_stream_buffer.sv
// Directed self-checking bench for wifi_tx_stream_buffer (payload, bubbles, stalls, abort, reset, FCS).
module tb_wifi_tx_stream_buffer;

`ifdef WIFI_TX_FCS_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        tx_start;
    logic [9:0]  tx_len;
    logic        tx_abort;
    logic        busy;
    logic        done;

    wifi_tx_stream_buffer_if tx_if();

    wifi_tx_stream_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .tx_start (tx_start),
        .tx_len   (tx_len),
        .tx_abort (tx_abort),
        .busy     (busy),
        .done     (done),
        .tx_if    (tx_if.master)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] mem [0:255];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [7:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        mem[a]  = d;
        step();
        wr_en   = 1'b0;
    endtask

    // Bit-at-a-time reflected CRC-32 reference.
    function automatic logic [31:0] crc_ref(input int n);
        logic [31:0] c;
        logic        fb;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) begin
            b = exp_q[k];
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ b[i];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic build_exp(input int len);
        logic [31:0] w;
        logic [31:0] crc;
        exp_q.delete();
        for (int k = 0; k < len; k++) begin
            w = mem[k / 4];
            exp_q.push_back(w[8 * (k % 4) +: 8]);
        end
        if (FCS_ON) begin
            crc = crc_ref(len);
            for (int i = 0; i < 4; i++) exp_q.push_back(crc[8 * i +: 8]);
        end
    endtask

    // Start a frame, drain it with optional stall and ignored restart, then compare to exp_q.
    task automatic run_frame(input string tag, input int len, input int stall_idx,
                             input int stall_n, input int restart_cyc);
        int stalled;
        int last_idx;
        bit fin;
        bit done_seen;
        got_q.delete();
        stalled   = 0;
        last_idx  = -1;
        fin       = 1'b0;
        done_seen = 1'b0;
        tx_len    = 10'(len);
        tx_start  = 1'b1;
        step();
        tx_start  = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (c == restart_cyc) begin
                tx_start = 1'b1;
                tx_len   = 10'd8;
            end else begin
                tx_start = 1'b0;
            end
            if (tx_if.out_valid && (got_q.size() == stall_idx) && (stalled < stall_n)) begin
                tx_if.out_ready = 1'b0;
                chk({tag, "_stall_data"}, 32'(tx_if.out_data), 32'(exp_q[stall_idx]));
                stalled++;
            end else begin
                tx_if.out_ready = 1'b1;
            end
            if (tx_if.out_valid && tx_if.out_ready) begin
                got_q.push_back(tx_if.out_data);
                if (tx_if.out_last) last_idx = got_q.size() - 1;
            end
            if (done) begin
                done_seen = 1'b1;
                fin       = 1'b1;
            end
            step();
        end
        tx_start        = 1'b0;
        tx_if.out_ready = 1'b1;
        chk({tag, "_timeout"}, 32'(fin), 32'd1);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
        end
        chk({tag, "_last_idx"}, 32'(last_idx), 32'(exp_q.size() - 1));
        chk({tag, "_done"}, 32'(done_seen), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [8:0] t1_vd [9];
    logic       t1_last;

    initial begin
        reset           = 1'b0;
        wr_en           = 1'b0;
        wr_addr         = '0;
        wr_data         = '0;
        tx_start        = 1'b0;
        tx_len          = '0;
        tx_abort        = 1'b0;
        tx_if.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) step();

        chk("rst_valid", 32'(tx_if.out_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_last",  32'(tx_if.out_last), 32'd0);
        chk("rst_data",  32'(tx_if.out_data), 32'd0);
        reset = 1'b1;
        step();

        wr_word(8'd0, 32'h4433_2211);
        wr_word(8'd1, 32'h8877_6655);

        // Cycle-exact len=8: four bytes, one bubble, four bytes.
        t1_vd = '{9'h111, 9'h122, 9'h133, 9'h144, 9'h000, 9'h155, 9'h166, 9'h177, 9'h188};
        build_exp(8);
        tx_len   = 10'd8;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        chk("t1_fetch_valid", 32'(tx_if.out_valid), 32'd0);
        chk("t1_fetch_busy",  32'(busy), 32'd1);
        step();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t1_valid%0d", i), 32'(tx_if.out_valid), 32'(t1_vd[i][8]));
            if (t1_vd[i][8]) begin
                t1_last = (i == 8) && !FCS_ON;
                chk($sformatf("t1_data%0d", i), 32'(tx_if.out_data), 32'(t1_vd[i][7:0]));
                chk($sformatf("t1_last%0d", i), 32'(tx_if.out_last), 32'(t1_last));
            end
            step();
        end
        if (FCS_ON) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t1_fcs_valid%0d", i), 32'(tx_if.out_valid), 32'd1);
                chk($sformatf("t1_fcs_data%0d", i), 32'(tx_if.out_data), 32'(exp_q[8 + i]));
                chk($sformatf("t1_fcs_last%0d", i), 32'(tx_if.out_last), 32'(i == 3));
                step();
            end
        end
        chk("t1_done",       32'(done), 32'd1);
        chk("t1_done_valid", 32'(tx_if.out_valid), 32'd0);
        chk("t1_done_busy",  32'(busy), 32'd1);
        step();
        chk("t1_idle_done", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        build_exp(5);
        run_frame("t2_len5", 5, -1, 0, -1);

        build_exp(8);
        run_frame("t3_stall", 8, 2, 3, -1);

        // Abort while byte 0x44 is presented.
        tx_len   = 10'd8;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (4) step();
        chk("t4_pre_data", 32'(tx_if.out_data), 32'h44);
        tx_abort = 1'b1;
        step();
        tx_abort = 1'b0;
        chk("t4_valid", 32'(tx_if.out_valid), 32'd0);
        chk("t4_busy",  32'(busy), 32'd0);
        chk("t4_done",  32'(done), 32'd0);
        step();
        chk("t4_done2", 32'(done), 32'd0);
        build_exp(8);
        run_frame("t4_replay", 8, -1, 0, -1);

        // Zero length start is ignored.
        tx_len   = 10'd0;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        chk("t5_busy",  32'(busy), 32'd0);
        chk("t5_valid", 32'(tx_if.out_valid), 32'd0);
        step();
        chk("t5_busy2", 32'(busy), 32'd0);
        chk("t5_done",  32'(done), 32'd0);

        build_exp(5);
        run_frame("t6_restart", 5, -1, 0, 2);

        // Asynchronous reset mid-stream.
        tx_len   = 10'd8;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (2) step();
        chk("t7_pre_valid", 32'(tx_if.out_valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("t7_valid", 32'(tx_if.out_valid), 32'd0);
        chk("t7_busy",  32'(busy), 32'd0);
        chk("t7_data",  32'(tx_if.out_data), 32'd0);
        chk("t7_last",  32'(tx_if.out_last), 32'd0);
        reset = 1'b1;
        step();
        chk("t7_post_done",  32'(done), 32'd0);
        chk("t7_post_valid", 32'(tx_if.out_valid), 32'd0);

        // Abort coincident with the last payload handshake.
        tx_len   = 10'd5;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (6) step();
        chk("t8_pre_data", 32'(tx_if.out_data), 32'h55);
        tx_abort = 1'b1;
        step();
        tx_abort = 1'b0;
        chk("t8_done",  32'(done), 32'd0);
        chk("t8_busy",  32'(busy), 32'd0);
        chk("t8_valid", 32'(tx_if.out_valid), 32'd0);
        step();
        chk("t8_done2", 32'(done), 32'd0);

`ifdef WIFI_TX_FCS_EN
        wr_word(8'd0, 32'h3433_3231);
        wr_word(8'd1, 32'h3837_3635);
        wr_word(8'd2, 32'h0000_0039);
        build_exp(9);
        run_frame("t9_fcs", 9, -1, 0, -1);
        chk("t9_fcs0", (got_q.size() > 9)  ? 32'(got_q[9])  : 32'hDEAD, 32'h26);
        chk("t9_fcs1", (got_q.size() > 10) ? 32'(got_q[10]) : 32'hDEAD, 32'h39);
        chk("t9_fcs2", (got_q.size() > 11) ? 32'(got_q[11]) : 32'hDEAD, 32'hF4);
        chk("t9_fcs3", (got_q.size() > 12) ? 32'(got_q[12]) : 32'hDEAD, 32'hCB);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
